// File: rtl/xbar_rr_arbiter_pkg.sv
// Shared types and defaults for the crossbar peripheral-port arbiter.
package xbar_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int XBAR_N_CONTROLLERS      = 3;
    localparam int XBAR_ARB_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/xbar_rr_arbiter_if.sv
// Handshake bundle between the crossbar controllers/peripheral and the arbiter.
// slave: the arbiter side; master: the controller/peripheral side.
interface xbar_rr_arbiter_if
    import xbar_pkg::*;
#(
    parameter int N_REQ = XBAR_N_CONTROLLERS
) ();

    logic [N_REQ-1:0] req_i;
    logic             p_ready_i;
    logic [N_REQ-1:0] gnt_o;
    logic [N_REQ-1:0] ready_o;
    logic             p_req_o;
    logic             timeout_o;

    modport slave (
        input  req_i,
        input  p_ready_i,
        output gnt_o,
        output ready_o,
        output p_req_o,
        output timeout_o
    );

    modport master (
        output req_i,
        output p_ready_i,
        input  gnt_o,
        input  ready_o,
        input  p_req_o,
        input  timeout_o
    );

endinterface

// File: rtl/xbar_rr_arbiter_pick.sv
// Combinational round-robin pick: first unmasked request at or after ptr,
// scanning upward and wrapping explicitly at N_REQ (non-power-of-two safe).
module xbar_rr_pick #(
    parameter int N_REQ = 3,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);

    logic [N_REQ-1:0] cand;
    logic [PW:0]      idx;

    assign cand = req & ~mask;

    // Scan N_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N_REQ)) begin
                idx = idx - (PW+1)'(N_REQ);
            end
            if (!valid && cand[idx[PW-1:0]]) begin
                pick[idx[PW-1:0]] = 1'b1;
                valid             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter for one crossbar peripheral port. Holds a registered
// one-hot grant per transaction and rotates priority on completion.
// Optional grant timeout enabled by defining XBAR_ARB_TIMEOUT_EN.
module xbar_rr_arbiter
    import xbar_pkg::*;
#(
    parameter int N_REQ          = XBAR_N_CONTROLLERS,
    parameter int TIMEOUT_CYCLES = XBAR_ARB_TIMEOUT_CYCLES
) (
    input  logic            clk_i,
    input  logic            rst_i,
    xbar_rr_arbiter_if.slave bus
);

    localparam int PW = $clog2(N_REQ);

    arb_state_e       state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [PW-1:0]    prio_q;

    logic [PW-1:0]    g_idx;
    logic [PW-1:0]    next_prio;
    logic [PW-1:0]    pick_ptr;
    logic [N_REQ-1:0] pick_mask;
    logic [N_REQ-1:0] pick;
    logic             pick_valid;
    logic             tmo_hit;
    logic             done;

    // Index of the currently granted controller (grant is one-hot).
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                g_idx = PW'(i);
            end
        end
    end

    assign next_prio = (g_idx == PW'(N_REQ-1)) ? '0 : g_idx + 1'b1;

`ifdef XBAR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES+1);
    logic [CW-1:0] cnt_q;

    assign tmo_hit = (state_q == GRANT) && !bus.p_ready_i &&
                     (cnt_q == CW'(TIMEOUT_CYCLES-1));

    // Counts stalled grant cycles; restarts whenever a grant starts or ends.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == IDLE || done) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign done = (state_q == GRANT) && (bus.p_ready_i || tmo_hit);

    // On completion, re-arbitrate from the advanced pointer with the finishing
    // controller masked so its stale request cannot win again.
    assign pick_ptr  = done ? next_prio : prio_q;
    assign pick_mask = done ? gnt_q : '0;

    xbar_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req   (bus.req_i),
        .mask  (pick_mask),
        .ptr   (pick_ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    // Arbitration FSM: grant, hold until completion/timeout/abort, rotate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            prio_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= pick;
                        state_q <= GRANT;
                    end else begin
                        gnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (done) begin
                        prio_q <= next_prio;
                        if (pick_valid) begin
                            gnt_q   <= pick;
                        end else begin
                            gnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end else if ((gnt_q & bus.req_i) == '0) begin
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.p_req_o   = |gnt_q;
    assign bus.ready_o   = gnt_q & {N_REQ{bus.p_ready_i | tmo_hit}};
    assign bus.timeout_o = tmo_hit;

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Self-checking bench for xbar_rr_arbiter (N_REQ=3). Build with
// XBAR_ARB_TIMEOUT_EN defined to exercise the timeout path.
module tb_xbar_rr_arbiter;

`ifdef XBAR_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    typedef struct {
        string      name;
        logic [2:0] req;
        logic       prdy;
        logic [2:0] exp_ready;
        logic       exp_tmo;
        logic [2:0] exp_gnt;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];
    logic [2:0] exp_q[$];

    xbar_rr_arbiter_if #(.N_REQ(3)) bus ();

    xbar_rr_arbiter #(
        .N_REQ          (3),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: act=%b exp=%b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [2:0] req, input logic prdy,
                                input logic [2:0] er, input logic et, input logic [2:0] eg);
        vec_t v;
        v.name = name; v.req = req; v.prdy = prdy;
        v.exp_ready = er; v.exp_tmo = et; v.exp_gnt = eg;
        return v;
    endfunction

    // Drive one cycle: check same-cycle ready/timeout, then the next-cycle grant.
    task automatic apply(input vec_t v);
        logic [2:0] eg;
        bus.req_i     = v.req;
        bus.p_ready_i = v.prdy;
        #1;
        check(bus.ready_o == v.exp_ready && bus.timeout_o == v.exp_tmo,
              {v.name, "/ready"}, {4'b0, bus.timeout_o, bus.ready_o},
              {4'b0, v.exp_tmo, v.exp_ready});
        exp_q.push_back(v.exp_gnt);
        @(posedge clk);
        #1;
        eg = exp_q.pop_front();
        check(bus.gnt_o == eg && bus.p_req_o == (|eg), {v.name, "/gnt"},
              {4'b0, bus.p_req_o, bus.gnt_o}, {4'b0, |eg, eg});
        $display("[TB] %-12s req=%b prdy=%b ready=%b tmo=%b -> gnt=%b", v.name, v.req, v.prdy,
                 v.exp_ready, v.exp_tmo, bus.gnt_o);
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end
        vecs.delete();
    endtask

    initial begin
        int bad;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.req_i = 3'b000;
        bus.p_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check(bus.gnt_o == 3'b000 && bus.ready_o == 3'b000 && !bus.p_req_o && !bus.timeout_o,
              "reset", {1'b0, bus.timeout_o, bus.p_req_o, 2'b0, bus.gnt_o | bus.ready_o}, 8'h00);
        rst = 1'b0;
        bus.p_ready_i = 1'b0;

        // single request, completion, pointer moves to 2
        vecs.push_back(mk("single_req", 3'b010, 1'b0, 3'b000, 1'b0, 3'b010));
        vecs.push_back(mk("single_hold", 3'b010, 1'b0, 3'b000, 1'b0, 3'b010));
        vecs.push_back(mk("single_done", 3'b010, 1'b1, 3'b010, 1'b0, 3'b000));
        // pointer at 2 -> bit 2 first, then back-to-back rotation
        vecs.push_back(mk("rr_start", 3'b111, 1'b0, 3'b000, 1'b0, 3'b100));
        vecs.push_back(mk("rr_b2b_1", 3'b111, 1'b1, 3'b100, 1'b0, 3'b001));
        vecs.push_back(mk("rr_b2b_2", 3'b111, 1'b1, 3'b001, 1'b0, 3'b010));
        vecs.push_back(mk("rr_b2b_3", 3'b111, 1'b1, 3'b010, 1'b0, 3'b100));
        vecs.push_back(mk("rr_b2b_4", 3'b111, 1'b1, 3'b100, 1'b0, 3'b001));
        vecs.push_back(mk("rr_b2b_5", 3'b111, 1'b1, 3'b001, 1'b0, 3'b010));
        vecs.push_back(mk("rr_end", 3'b000, 1'b1, 3'b010, 1'b0, 3'b000));
        // pointer at 2, only bit 0 asks; bit 2 rises mid-transaction, no preemption
        vecs.push_back(mk("nopre_req", 3'b001, 1'b0, 3'b000, 1'b0, 3'b001));
        vecs.push_back(mk("nopre_hold", 3'b101, 1'b0, 3'b000, 1'b0, 3'b001));
        vecs.push_back(mk("nopre_done", 3'b101, 1'b1, 3'b001, 1'b0, 3'b100));
        vecs.push_back(mk("nopre_end", 3'b100, 1'b1, 3'b100, 1'b0, 3'b000));
        // abort: pointer stays 0 so 111 then grants bit 0
        vecs.push_back(mk("abort_req", 3'b010, 1'b0, 3'b000, 1'b0, 3'b010));
        vecs.push_back(mk("abort_drop", 3'b000, 1'b0, 3'b000, 1'b0, 3'b000));
        vecs.push_back(mk("abort_prio", 3'b111, 1'b0, 3'b000, 1'b0, 3'b001));
        vecs.push_back(mk("abort_next", 3'b111, 1'b1, 3'b001, 1'b0, 3'b010));
        vecs.push_back(mk("to_bit2", 3'b110, 1'b1, 3'b010, 1'b0, 3'b100));
        vecs.push_back(mk("bit2_hold", 3'b100, 1'b0, 3'b000, 1'b0, 3'b100));
        run_table();

        // asynchronous reset while bit 2 is granted
        #1;
        rst = 1'b1;
        #1;
        check(bus.gnt_o == 3'b000 && !bus.p_req_o, "async_rst",
              {4'b0, bus.p_req_o, bus.gnt_o}, 8'h00);
        $display("[TB] %-12s rst pulse mid-cycle -> gnt=%b", "async_rst", bus.gnt_o);
        @(posedge clk);
        #1;
        rst = 1'b0;

        vecs.push_back(mk("post_rst", 3'b101, 1'b0, 3'b000, 1'b0, 3'b001));
        vecs.push_back(mk("post_done", 3'b101, 1'b1, 3'b001, 1'b0, 3'b100));
        vecs.push_back(mk("post_end", 3'b000, 1'b1, 3'b100, 1'b0, 3'b000));
        vecs.push_back(mk("stall_req", 3'b010, 1'b0, 3'b000, 1'b0, 3'b010));
        run_table();

`ifdef XBAR_ARB_TIMEOUT_EN
        vecs.push_back(mk("stall_c1", 3'b110, 1'b0, 3'b000, 1'b0, 3'b010));
        vecs.push_back(mk("stall_c2", 3'b110, 1'b0, 3'b000, 1'b0, 3'b010));
        vecs.push_back(mk("stall_c3", 3'b110, 1'b0, 3'b000, 1'b0, 3'b010));
        vecs.push_back(mk("timeout", 3'b110, 1'b0, 3'b010, 1'b1, 3'b100));
        vecs.push_back(mk("late_rdy", 3'b100, 1'b1, 3'b100, 1'b0, 3'b000));
        run_table();
`else
        // grant must stay on bit 1 indefinitely
        bus.req_i     = 3'b110;
        bus.p_ready_i = 1'b0;
        bad = 0;
        for (int c = 0; c < 1001; c++) begin
            @(posedge clk);
            #1;
            if (bus.gnt_o != 3'b010 || bus.timeout_o || bus.ready_o != 3'b000) bad++;
        end
        check(bad == 0, "long_hold", 8'(bad), 8'd0);
        $display("[TB] %-12s 1001 stalled cycles, deviations=%0d", "long_hold", bad);
        vecs.push_back(mk("hold_done", 3'b110, 1'b1, 3'b010, 1'b0, 3'b100));
        run_table();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
